// File: rtl/elevador_pkg.sv
// elevador_pkg: shared state encoding, floor count default and floor-to-display conversion
package elevador_pkg;

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        FALLA    = 2'd3
    } estado_t;

    localparam int N_PISOS_DEF = 3;

    function automatic logic [3:0] piso_a_dato(input logic [3:0] p);
        return p + 4'd1;
    endfunction

endpackage

// File: rtl/elevador_tick_cnt.sv
// elevador_tick_cnt: travel-time counter with clear, enable and terminal count
module elevador_tick_cnt #(
    parameter int TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(TICKS);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc = cnt_q == W'(TICKS - 1);

    always_comb cnt_d = clr ? '0 : !en ? cnt_q : tc ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

endmodule

// File: rtl/elevador_cabina.sv
// elevador_cabina: timed elevator car plant answering the controller's motor commands
module elevador_cabina
    import elevador_pkg::*;
#(
    parameter int N_PISOS    = N_PISOS_DEF,
    parameter int TICKS_PISO = 4,
    parameter int W_PISO     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              motorsubir,
    input  logic              motorbajar,
    output logic [W_PISO-1:0] piso,
    output logic [3:0]        dato,
    output logic              sensor_piso,
    output logic              en_movimiento,
    output logic              fin_sup,
    output logic              fin_inf,
    output logic              falla
);
    localparam logic [W_PISO-1:0] TOPE = W_PISO'(N_PISOS - 1);

    estado_t           estado_q, estado_d;
    logic [W_PISO-1:0] piso_q, piso_d;
    logic [3:0]        dato_q, dato_d;
    logic              sensor_q, sensor_d, mov_q, mov_d, falla_q, falla_d;
    logic              cnt_clr, cnt_en, tc;
    logic [1:0]        cmd, dir;

    elevador_tick_cnt #(.TICKS(TICKS_PISO)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .en (cnt_en),
        .tc (tc)
    );

    assign cmd = {motorsubir, motorbajar};
    assign dir = estado_q == SUBIENDO ? 2'b10 : 2'b01;

    always_comb begin
        estado_d = estado_q;
        piso_d   = piso_q;
        sensor_d = sensor_q;
        mov_d    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (estado_q)
            PARADO:
                if (cmd == 2'b10 && piso_q != TOPE) begin
                    estado_d = SUBIENDO;
                    cnt_clr  = 1'b1;
                    sensor_d = 1'b0;
                    mov_d    = 1'b1;
                end else if (cmd == 2'b01 && piso_q != '0) begin
                    estado_d = BAJANDO;
                    cnt_clr  = 1'b1;
                    sensor_d = 1'b0;
                    mov_d    = 1'b1;
                end else if (cmd != 2'b00) begin
                    estado_d = FALLA;
                end
            SUBIENDO, BAJANDO:
                if (cmd == dir) begin
                    cnt_en = 1'b1;
                    if (tc) begin
                        estado_d = PARADO;
                        sensor_d = 1'b1;
                        piso_d   = estado_q == SUBIENDO ? piso_q + 1'b1 : piso_q - 1'b1;
                    end else begin
                        mov_d = 1'b1;
                    end
                end else if (cmd != 2'b00) begin
                    estado_d = FALLA;
                end
            default: ;
        endcase
        falla_d = estado_d == FALLA;
        dato_d  = piso_a_dato(4'(piso_d));
    end

    always_ff @(posedge clk)
        if (rst) begin
            estado_q <= PARADO;
            piso_q   <= '0;
            dato_q   <= 4'd1;
            sensor_q <= 1'b1;
            mov_q    <= 1'b0;
            falla_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            piso_q   <= piso_d;
            dato_q   <= dato_d;
            sensor_q <= sensor_d;
            mov_q    <= mov_d;
            falla_q  <= falla_d;
        end

    assign piso          = piso_q;
    assign dato          = dato_q;
    assign sensor_piso   = sensor_q;
    assign en_movimiento = mov_q;
    assign falla         = falla_q;
    assign fin_sup       = piso_q == TOPE && sensor_q;
    assign fin_inf       = piso_q == '0 && sensor_q;

endmodule

// File: tb/tb_elevador_cabina.sv
// tb_elevador_cabina: scoreboard bench for the elevator car plant with directed scenarios
module tb_elevador_cabina;

    logic       clk = 1'b0;
    logic       rst, motorsubir, motorbajar;
    logic [1:0] piso;
    logic [3:0] dato;
    logic       sensor_piso, en_movimiento, fin_sup, fin_inf, falla;
    logic [10:0] obs;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int          cyc;
        string       nm;
        logic [10:0] e;
    } sb_t;

    sb_t q[$];
    sb_t t_mon;

    elevador_cabina #(.N_PISOS(3), .TICKS_PISO(4), .W_PISO(2)) dut (
        .clk(clk),
        .rst(rst),
        .motorsubir(motorsubir),
        .motorbajar(motorbajar),
        .piso(piso),
        .dato(dato),
        .sensor_piso(sensor_piso),
        .en_movimiento(en_movimiento),
        .fin_sup(fin_sup),
        .fin_inf(fin_inf),
        .falla(falla)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {piso, dato, sensor_piso, en_movimiento, fin_sup, fin_inf, falla};

    // expected snapshot {piso,dato,sensor,mov,fin_sup,fin_inf,falla} for a 3-floor shaft
    function automatic logic [10:0] mk(input logic [1:0] p, input logic s, input logic m, input logic f);
        return {p, 4'(p) + 4'd1, s, m, (p == 2'd2) && s, (p == 2'd0) && s, f};
    endfunction

    always @(negedge clk)
        if (q.size() > 0 && q[0].cyc == cyc) begin
            t_mon = q.pop_front();
            checks++;
            if (obs !== t_mon.e) begin
                errors++;
                $display("FAIL %s cyc=%0d got piso=%0d dato=%0d sen=%0b mov=%0b fs=%0b fi=%0b falla=%0b exp %b_%b_%b%b%b%b%b",
                         t_mon.nm, cyc, piso, dato, sensor_piso, en_movimiento, fin_sup, fin_inf, falla,
                         t_mon.e[10:9], t_mon.e[8:5], t_mon.e[4], t_mon.e[3], t_mon.e[2], t_mon.e[1], t_mon.e[0]);
            end
        end

    task automatic tick(input logic r, input logic s, input logic b, input string nm, input logic [10:0] e);
        rst        = r;
        motorsubir = s;
        motorbajar = b;
        q.push_back('{cyc + 1, nm, e});
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        motorsubir = 1'b0;
        motorbajar = 1'b0;
        @(posedge clk);
        #2;
        tick(1, 0, 0, "reset", mk(0, 1, 0, 0));
        for (int i = 0; i < 5; i++) tick(0, 0, 0, "idle", mk(0, 1, 0, 0));

        for (int i = 0; i < 4; i++) tick(0, 1, 0, "up1_travel", mk(0, 0, 1, 0));
        tick(0, 1, 0, "up1_arrive", mk(1, 1, 0, 0));
        for (int i = 0; i < 4; i++) tick(0, 1, 0, "up2_travel", mk(1, 0, 1, 0));
        tick(0, 1, 0, "up2_arrive_top", mk(2, 1, 0, 0));

        tick(0, 1, 0, "overtravel_top", mk(2, 1, 0, 1));
        tick(0, 0, 0, "falla_sticky", mk(2, 1, 0, 1));
        tick(0, 1, 1, "falla_ignores", mk(2, 1, 0, 1));
        tick(1, 0, 0, "rst_from_falla", mk(0, 1, 0, 0));

        tick(0, 1, 1, "both_floor0", mk(0, 1, 0, 1));
        tick(0, 0, 0, "both_hold", mk(0, 1, 0, 1));
        tick(1, 0, 0, "rst2", mk(0, 1, 0, 0));
        tick(0, 0, 1, "down_floor0", mk(0, 1, 0, 1));
        tick(1, 0, 0, "rst3", mk(0, 1, 0, 0));

        for (int i = 0; i < 2; i++) tick(0, 1, 0, "pause_pre", mk(0, 0, 1, 0));
        for (int i = 0; i < 5; i++) tick(0, 0, 0, "pause_stall", mk(0, 0, 0, 0));
        for (int i = 0; i < 2; i++) tick(0, 1, 0, "pause_resume", mk(0, 0, 1, 0));
        tick(0, 1, 0, "pause_arrive", mk(1, 1, 0, 0));

        for (int i = 0; i < 4; i++) tick(0, 0, 1, "down_travel", mk(1, 0, 1, 0));
        tick(0, 0, 1, "down_arrive", mk(0, 1, 0, 0));
        tick(0, 0, 0, "down_idle", mk(0, 1, 0, 0));

        for (int i = 0; i < 3; i++) tick(0, 1, 0, "rev_pre", mk(0, 0, 1, 0));
        tick(0, 0, 1, "reversal", mk(0, 0, 0, 1));
        tick(0, 0, 0, "reversal_hold", mk(0, 0, 0, 1));
        tick(1, 0, 0, "rst4", mk(0, 1, 0, 0));

        for (int i = 0; i < 2; i++) tick(0, 1, 0, "mid_pre", mk(0, 0, 1, 0));
        tick(1, 1, 0, "rst_mid", mk(0, 1, 0, 0));
        tick(0, 0, 0, "rst_mid_idle", mk(0, 1, 0, 0));
        for (int i = 0; i < 4; i++) tick(0, 1, 0, "after_rst_travel", mk(0, 0, 1, 0));
        tick(0, 1, 0, "after_rst_arrive", mk(1, 1, 0, 0));

        motorsubir = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
